// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and default sizing for the round-robin grant scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rr_sched_pkg;

    // Default number of requesters sharing the downstream resource
    localparam int N_REQ_DEF    = 16;
    // Width of a requester index; clog2(N_REQ_DEF)
    localparam int IDX_W_DEF    = 4;
    // Longest a single grantee may keep the resource, in cycles (1..255)
    localparam int MAX_HOLD_DEF = 8;
    // Width of the hold counter; wide enough for the full legal MAX_HOLD range
    localparam int HOLD_W       = 8;

    // Scheduler FSM encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : rr_sched_pkg

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the requesters and the round-robin scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; req is a level, done a one-cycle pulse from the grantee.
interface rr_sched_if
    import rr_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
);

    logic [N_REQ-1:0] req;
    logic             done;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_onehot;
    logic             timeout;
    logic [IDX_W-1:0] ptr;

    // Scheduler side: consumes requests, produces the grant stream
    modport slave (
        input  req,
        input  done,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output timeout,
        output ptr
    );

    // Requester side: drives requests and completion, observes grants
    modport master (
        output req,
        output done,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  timeout,
        input  ptr
    );

endinterface : rr_sched_if

// File: rtl/rr_grant_scheduler_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // The request vector is duplicated so that the wrapped search becomes a
    // plain lowest-set-bit search: bits below ptr in the lower copy are
    // masked off, the upper copy stays whole and supplies the wrapped part.
    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_masked;
    logic               w_found;

    // Build the double-width vector and mask the positions below ptr
    always_comb begin
        w_dbl    = {req, req};
        w_masked = '0;
        for (int b = 0; b < 2 * N_REQ; b++) begin
            w_masked[b] = w_dbl[b] & (b >= int'(ptr));
        end
    end

    // Fixed-priority encode of the masked vector, folded back to N_REQ range
    always_comb begin
        w_found = 1'b0;
        idx     = '0;
        for (int b = 0; b < 2 * N_REQ; b++) begin
            if (!w_found && w_masked[b]) begin
                w_found = 1'b1;
                idx     = IDX_W'(b % N_REQ);
            end
        end
    end

    // Any request at all guarantees a hit somewhere in the upper copy
    assign any = |req;

endmodule : rr_pick

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: grants one of N_REQ requesters, held until done/withdraw/hold limit.
// Latency: request sampled in IDLE -> registered grant after one edge; release -> outputs clear after one edge.
// Backpressure: none; no preemption, other requesters simply wait their rotating turn.
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    rr_sched_if.slave  bus
);

    // Legacy-style state constants mirroring the package enum
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_GRANT = GRANT;

    // Hold-counter value on the last cycle a grant is allowed to persist
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_grant_valid;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [N_REQ-1:0]  r_grant_onehot;
    logic              r_timeout;

    logic              w_pick_any;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [N_REQ-1:0]  w_pick_onehot;
    logic              w_own_req;
    logic              w_hold_last;
    logic              w_release;
    logic              w_forced;
    logic [IDX_W-1:0]  w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (bus.req),
        .ptr (r_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    // Release decision for the current grant; done and withdraw take priority
    // over the hold limit, so only an otherwise-clean limit hit is "forced".
    always_comb begin
        w_pick_onehot = N_REQ'(1) << w_pick_idx;
        w_own_req     = bus.req[r_grant_idx];
        w_hold_last   = (r_hold_cnt == HOLD_LAST);
        w_release     = bus.done | ~w_own_req | w_hold_last;
        w_forced      = ~bus.done & w_own_req & w_hold_last;
        w_ptr_next    = (r_grant_idx == IDX_LAST) ? '0 : r_grant_idx + 1'b1;
    end

    // FSM, rotating pointer, hold counter and registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_hold_cnt     <= '0;
            r_grant_valid  <= 1'b0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_state        <= ST_GRANT;
                        r_hold_cnt     <= '0;
                        r_grant_valid  <= 1'b1;
                        r_grant_idx    <= w_pick_idx;
                        r_grant_onehot <= w_pick_onehot;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state        <= ST_IDLE;
                        r_ptr          <= w_ptr_next;
                        r_hold_cnt     <= '0;
                        r_grant_valid  <= 1'b0;
                        r_grant_idx    <= '0;
                        r_grant_onehot <= '0;
                        r_timeout      <= w_forced;
                    end else if (r_hold_cnt != HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers, so no combinational path from req
    always_comb begin
        bus.grant_valid  = r_grant_valid;
        bus.grant_idx    = r_grant_idx;
        bus.grant_onehot = r_grant_onehot;
        bus.timeout      = r_timeout;
        bus.ptr          = r_ptr;
    end

endmodule : rr_grant_scheduler

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler: cycle model feeding a scoreboard plus directed checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_grant_scheduler;
    import rr_sched_pkg::*;

    localparam int NR = 16;
    localparam int IW = 4;
    localparam int MH = 8;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] idx;
        logic [NR-1:0] oh;
        logic          to;
        logic [IW-1:0] ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_sched_if #(.N_REQ(NR), .IDX_W(IW)) bus ();

    rr_grant_scheduler #(.N_REQ(NR), .IDX_W(IW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference model state
    logic m_valid = 1'b0;
    int   m_idx   = 0;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the inputs currently driven, push its prediction,
    // clock the DUT and compare against the popped prediction.
    task automatic step();
        exp_t e;
        int   j;
        logic found;
        if (rst) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (!m_valid) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    j = (m_ptr + k) % NR;
                    if (!found && bus.req[j]) begin
                        found = 1'b1; m_idx = j; m_valid = 1'b1; m_hold = 0;
                    end
                end
            end else if (bus.done || !bus.req[m_idx] || m_hold == MH - 1) begin
                m_to    = !bus.done && bus.req[m_idx];
                m_ptr   = (m_idx + 1) % NR;
                m_valid = 1'b0;
                m_idx   = 0;
                m_hold  = 0;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
        e.v   = m_valid;
        e.idx = IW'(m_idx);
        e.oh  = m_valid ? (NR'(1) << m_idx) : '0;
        e.to  = m_to;
        e.ptr = IW'(m_ptr);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("sb_valid",  32'(bus.grant_valid),  32'(e.v));
            chk("sb_idx",    32'(bus.grant_idx),    32'(e.idx));
            chk("sb_onehot", 32'(bus.grant_onehot), 32'(e.oh));
            chk("sb_timeout",32'(bus.timeout),      32'(e.to));
            chk("sb_ptr",    32'(bus.ptr),          32'(e.ptr));
        end
    endtask

    initial begin
        int seq[$];
        int cnt;
        int n_to;

        bus.req  = '0;
        bus.done = 1'b0;

        // Reset for two cycles
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid",  32'(bus.grant_valid),  32'd0);
        chk("rst_idx",    32'(bus.grant_idx),    32'd0);
        chk("rst_onehot", 32'(bus.grant_onehot), 32'd0);
        chk("rst_ptr",    32'(bus.ptr),          32'd0);

        // Single request, then done
        bus.req = 16'h0008;
        step();
        chk("t1_valid",  32'(bus.grant_valid),  32'd1);
        chk("t1_idx",    32'(bus.grant_idx),    32'd3);
        chk("t1_onehot", 32'(bus.grant_onehot), 32'h0008);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("t1_drop", 32'(bus.grant_valid), 32'd0);
        chk("t1_ptr",  32'(bus.ptr),         32'd4);
        bus.req = '0;
        bus.done = 1'b1;   // done while idle must be ignored
        step();
        bus.done = 1'b0;

        // Rotation fairness from ptr=0
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 16'hFFFF;
        for (int i = 0; i < 34; i++) begin
            bus.done = m_valid;
            step();
            if (bus.grant_valid) seq.push_back(int'(bus.grant_idx));
        end
        bus.done = 1'b0;
        chk("rot_count", 32'(seq.size()), 32'd17);
        for (int i = 0; i < seq.size() && i < 17; i++) begin
            chk($sformatf("rot_seq%0d", i), 32'(seq[i]), 32'(i % 16));
        end
        bus.req = '0;
        step();

        // Wrap-around: grant 14, then 15, then 0
        bus.req = 16'h4000;
        step();
        chk("wrap_g14", 32'(bus.grant_idx), 32'd14);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        chk("wrap_ptr15", 32'(bus.ptr), 32'd15);
        bus.req = 16'h8001;
        step();
        chk("wrap_g15", 32'(bus.grant_idx), 32'd15);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        chk("wrap_ptr0", 32'(bus.ptr), 32'd0);
        step();
        chk("wrap_g0", 32'(bus.grant_idx), 32'd0);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        bus.req = '0;
        step();

        // Hold-limit timeout on requester 5
        bus.req = 16'h0020;
        step();
        cnt = 0;
        n_to = 0;
        while (bus.grant_valid && cnt < 20) begin
            cnt++;
            step();
            if (bus.timeout) n_to++;
        end
        chk("to_hold_cycles", 32'(cnt), MH);
        chk("to_pulse",       32'(bus.timeout), 32'd1);
        step();
        if (bus.timeout) n_to++;
        chk("to_pulse_count", 32'(n_to), 32'd1);
        chk("to_regrant",     32'(bus.grant_valid), 32'd1);
        chk("to_regrant_idx", 32'(bus.grant_idx),   32'd5);
        bus.req = '0;
        step(); step();

        // Withdraw together with done: normal release
        bus.req = 16'h0004;
        step();
        chk("col_g2", 32'(bus.grant_idx), 32'd2);
        bus.req = '0; bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("col_wd_to",    32'(bus.timeout),     32'd0);
        chk("col_wd_valid", 32'(bus.grant_valid), 32'd0);

        // done on the very cycle the hold limit is reached: no timeout
        bus.req = 16'h0004;
        step();
        for (int i = 0; i < MH - 1; i++) step();
        chk("col_lim_still", 32'(bus.grant_valid), 32'd1);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("col_lim_to",    32'(bus.timeout),     32'd0);
        chk("col_lim_valid", 32'(bus.grant_valid), 32'd0);
        bus.req = '0;
        step();

        // Synchronous reset in the middle of a grant to 9
        bus.req = 16'h0200;
        step();
        chk("rm_g9", 32'(bus.grant_idx), 32'd9);
        step();
        rst = 1'b1;
        step();
        chk("rm_valid", 32'(bus.grant_valid), 32'd0);
        chk("rm_idx",   32'(bus.grant_idx),   32'd0);
        chk("rm_ptr",   32'(bus.ptr),         32'd0);
        chk("rm_to",    32'(bus.timeout),     32'd0);
        rst = 1'b0;
        bus.req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_grant_scheduler
